// File: rtl/mac_vec_loader_pkg.sv
// Shared defaults and state encodings for the MAC operand loader.
package mac_vec_loader_pkg;

  localparam int BW    = 8;
  localparam int PR    = 8;
  localparam int LEN_W = $clog2(PR + 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } out_state_t;

endpackage

// File: rtl/mac_vec_loader_if.sv
// Input pair stream and packed vector output of the loader.
interface mac_vec_loader_if
  import mac_vec_loader_pkg::*;
#(
  parameter int bw = BW,
  parameter int pr = PR
);

  logic                     in_valid;
  logic                     in_ready;
  logic [bw-1:0]            in_a;
  logic [bw-1:0]            in_b;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [pr*bw-1:0]         out_a;
  logic [pr*bw-1:0]         out_b;
  logic [$clog2(pr+1)-1:0]  out_len;

  // master: the environment feeding pairs and consuming vectors
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_len
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_a, out_b, out_len
  );

endinterface

// File: rtl/mac_vec_loader_fill_buf.sv
// One lane-packed fill buffer; clear with simultaneous write leaves only the written lane.
module vec_fill_buf
  import mac_vec_loader_pkg::*;
#(
  parameter int bw = BW,
  parameter int pr = PR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    we,
  input  logic [$clog2(pr)-1:0]   idx,
  input  logic [bw-1:0]           din,
  output logic [pr*bw-1:0]        dout
);

  generate
    for (genvar gi = 0; gi < pr; gi++) begin : g_lane
      logic [bw-1:0] lane_reg;

      // write wins over clear so a pair accepted at hand-over survives
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_reg <= '0;
        end else if (we && (idx == ($clog2(pr))'(gi))) begin
          lane_reg <= din;
        end else if (clr) begin
          lane_reg <= '0;
        end
      end

      assign dout[gi*bw +: bw] = lane_reg;
    end
  endgenerate

endmodule

// File: rtl/mac_vec_loader.sv
// Serial-to-parallel operand loader: fills a vector lane by lane, hands it to a held output register.
module mac_vec_loader
  import mac_vec_loader_pkg::*;
#(
  parameter int bw = BW,
  parameter int pr = PR
) (
  input  logic           clk,
  input  logic           reset,
  mac_vec_loader_if.slave bus
);

  localparam int idx_w = $clog2(pr);
  localparam int len_w = $clog2(pr + 1);

  fill_state_t       fill_reg;
  out_state_t        out_st_reg;
  logic [idx_w-1:0]  idx_reg;
  logic [len_w-1:0]  len_reg;
  logic [pr*bw-1:0]  out_a_reg;
  logic [pr*bw-1:0]  out_b_reg;
  logic [len_w-1:0]  out_len_reg;

  logic [pr*bw-1:0]  buf_a;
  logic [pr*bw-1:0]  buf_b;
  logic              slot_free;
  logic              handover;
  logic              accept;
  logic              last_lane;

  assign slot_free    = (out_st_reg == EMPTY) || bus.out_ready;
  assign handover     = (fill_reg == FULL) && slot_free;
  assign bus.in_ready = (fill_reg == FILL) || slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_lane    = bus.in_last || (idx_reg == idx_w'(pr - 1));

  // idx is always 0 while FULL, so an accept during hand-over lands in lane 0
  vec_fill_buf #(.bw(bw), .pr(pr)) u_buf_a (
    .clk   (clk),
    .reset (reset),
    .clr   (handover),
    .we    (accept),
    .idx   (idx_reg),
    .din   (bus.in_a),
    .dout  (buf_a)
  );

  vec_fill_buf #(.bw(bw), .pr(pr)) u_buf_b (
    .clk   (clk),
    .reset (reset),
    .clr   (handover),
    .we    (accept),
    .idx   (idx_reg),
    .din   (bus.in_b),
    .dout  (buf_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_reg    <= FILL;
      out_st_reg  <= EMPTY;
      idx_reg     <= '0;
      len_reg     <= '0;
      out_a_reg   <= '0;
      out_b_reg   <= '0;
      out_len_reg <= '0;
    end else begin
      if (handover) begin
        out_a_reg   <= buf_a;
        out_b_reg   <= buf_b;
        out_len_reg <= len_reg;
        out_st_reg  <= VALID;
      end else if ((out_st_reg == VALID) && bus.out_ready) begin
        out_st_reg  <= EMPTY;
      end

      if (accept) begin
        if (last_lane) begin
          len_reg  <= len_w'(idx_reg) + len_w'(1);
          idx_reg  <= '0;
          fill_reg <= FULL;
        end else begin
          idx_reg  <= idx_reg + idx_w'(1);
          fill_reg <= FILL;
        end
      end else if (handover) begin
        fill_reg <= FILL;
      end
    end
  end

  assign bus.out_valid = (out_st_reg == VALID);
  assign bus.out_a     = out_a_reg;
  assign bus.out_b     = out_b_reg;
  assign bus.out_len   = out_len_reg;

endmodule

// File: tb/tb_mac_vec_loader.sv
// Directed and random checks of mac_vec_loader against a vector-level scoreboard.
module tb_mac_vec_loader;
  import mac_vec_loader_pkg::*;

  localparam int W = BW * PR;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           len;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_vec_loader_if #(.bw(BW), .pr(PR)) bus ();

  mac_vec_loader #(.bw(BW), .pr(PR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           fire_cyc[$];
  vec_t         exp_q[$];
  logic [W-1:0] cur_a = '0;
  logic [W-1:0] cur_b = '0;
  int           cur_n = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    cur_a = '0;
    cur_b = '0;
    cur_n = 0;
  endtask

  // One clock: drive at edge+1, check at edge+2, model update at the edge.
  task automatic cycle(input logic v, input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input logic last, input logic ordy, output logic fired);
    logic in_fire;
    logic out_fire;
    vec_t e;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_last   = last;
    bus.out_ready = ordy;
    #1;
    check("in_ready", bus.in_ready, !(exp_q.size() == 2 && !ordy));
    in_fire  = v && bus.in_ready;
    out_fire = bus.out_valid && ordy;
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", bus.out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("out_a", bus.out_a, e.a);
        check("out_b", bus.out_b, e.b);
        check("out_len", bus.out_len, e.len);
        fire_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    cyc++;
    if (in_fire) begin
      cur_a[cur_n*BW +: BW] = a;
      cur_b[cur_n*BW +: BW] = b;
      cur_n++;
      if (cur_n == PR || last) begin
        e.a = cur_a;
        e.b = cur_b;
        e.len = cur_n;
        exp_q.push_back(e);
        cur_a = '0;
        cur_b = '0;
        cur_n = 0;
      end
    end
    #1;
    fired = in_fire;
  endtask

  task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b,
                      input logic last, input logic ordy);
    logic f;
    int   tries;
    f = 1'b0;
    tries = 0;
    while (!f && tries < 20) begin
      cycle(1'b1, a, b, last, ordy, f);
      tries++;
    end
    if (!f) check("send_timeout", f, 1'b1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic f;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, ordy, f);
  endtask

  initial begin
    logic         f;
    logic [W-1:0] held;
    logic [BW-1:0] a0;
    logic [BW-1:0] b0;
    int           tries;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_a", bus.out_a, '0);
    check("rst_out_b", bus.out_b, '0);
    check("rst_out_len", bus.out_len, '0);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // full vector a=1..8, b=-1
    for (int i = 1; i <= 8; i++) send(BW'(i), 8'hFF, 1'b0, 1'b1);
    check("lat_after_e", bus.out_valid, 1'b0);
    idle(1, 1'b1);
    check("lat_after_e1", bus.out_valid, 1'b1);
    check("full_out_a", bus.out_a, 64'h0807060504030201);
    check("full_out_b", bus.out_b, 64'hFFFFFFFFFFFFFFFF);
    check("full_out_len", bus.out_len, 8);
    idle(1, 1'b1);

    // short vector with zero padding
    send(8'h7F, 8'h10, 1'b0, 1'b1);
    send(8'h80, 8'h20, 1'b0, 1'b1);
    send(8'h01, 8'h30, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("short_out_a", bus.out_a, 64'h000000000001807F);
    check("short_out_b", bus.out_b, 64'h0000000000302010);
    check("short_out_len", bus.out_len, 3);
    idle(1, 1'b1);

    // back-to-back streaming
    fire_cyc.delete();
    for (int i = 0; i < 4 * PR; i++) begin
      cycle(1'b1, BW'($urandom), BW'($urandom), 1'b0, 1'b1, f);
      check("b2b_in_ready", f, 1'b1);
    end
    idle(3, 1'b1);
    check("b2b_fires", fire_cyc.size(), 4);
    for (int i = 1; i < fire_cyc.size(); i++)
      check("b2b_spacing", fire_cyc[i] - fire_cyc[i-1], 8);

    // backpressure: two vectors with out_ready low
    for (int i = 0; i < 2 * PR; i++) send(BW'($urandom), BW'($urandom), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    held = bus.out_a;
    check("bp_out_is_v1", held, exp_q[0].a);
    idle(3, 1'b0);
    check("bp_out_a_held", bus.out_a, held);
    check("bp_out_valid_held", bus.out_valid, 1'b1);
    fire_cyc.delete();
    idle(1, 1'b1);
    check("bp_v2_valid", bus.out_valid, 1'b1);
    check("bp_v2_data", bus.out_a, exp_q[0].a);
    idle(1, 1'b1);
    check("bp_two_fires", fire_cyc.size(), 2);
    if (fire_cyc.size() == 2) check("bp_fire_gap", fire_cyc[1] - fire_cyc[0], 1);

    // length-1 vector accepted during hand-over
    for (int i = 0; i < PR; i++) send(BW'($urandom), BW'($urandom), 1'b0, 1'b0);
    send(BW'($urandom), BW'($urandom), 1'b0, 1'b0);
    send(BW'($urandom), BW'($urandom), 1'b1, 1'b0);
    a0 = BW'($urandom);
    b0 = BW'($urandom);
    cycle(1'b1, a0, b0, 1'b1, 1'b1, f);
    check("edge_accept", f, 1'b1);
    idle(1, 1'b1);
    check("edge_len1_valid", bus.out_valid, 1'b1);
    check("edge_len1_a", bus.out_a, {{(W-BW){1'b0}}, a0});
    check("edge_len1_b", bus.out_b, {{(W-BW){1'b0}}, b0});
    check("edge_len1_len", bus.out_len, 1);
    idle(2, 1'b1);

    // asynchronous reset mid-vector with a pending output
    for (int i = 0; i < PR; i++) send(BW'($urandom_range(1, 255)), BW'($urandom_range(1, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(BW'($urandom), BW'($urandom), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_a", bus.out_a, '0);
    check("arst_out_b", bus.out_b, '0);
    check("arst_out_len", bus.out_len, '0);
    #2;
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check("arst_in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < PR; i++) send(BW'($urandom), BW'($urandom), 1'b0, 1'b1);
    idle(2, 1'b1);
    check("arst_clean_drained", exp_q.size(), 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, BW'($urandom), BW'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, f);
    tries = 0;
    while (exp_q.size() > 0 && tries < 40) begin
      idle(1, 1'b1);
      tries++;
    end
    check("rand_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_vec_loader.md
# mac_vec_loader

Serial-to-parallel operand loader on the input side of the MAC datapath. Accepts one signed `bw`-bit activation/weight pair per cycle over a valid/ready stream and packs `pr` pairs into lane-packed `a`/`b` vectors, lane 0 in the least-significant bits, for the `pr`-lane MAC. Double-buffered: one fill buffer and one output register, so streaming runs at one lane per cycle. A short vector ends early on `in_last`, and its unused lanes are zero-padded so they add nothing to the MAC sum.

## Interface
- `bw`, 8, bits per operand (signed two's complement)
- `pr`, 8, lanes per packed vector; must be ≥ 2
- `clk`  in  1  clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input pair valid
- `in_ready`  out  1  loader can accept a pair this cycle
- `in_a`  in  bw  activation operand
- `in_b`  in  bw  weight operand
- `in_last`  in  1  this pair is the final lane of the current vector
- `out_valid`  out  1  packed vector available
- `out_ready`  in  1  MAC side consumes the vector this cycle
- `out_a`  out  pr*bw  packed activations; lane i at bits [bw*(i+1)-1 : bw*i]
- `out_b`  out  pr*bw  packed weights; same packing as `out_a`
- `out_len`  out  $clog2(pr+1)  number of loaded lanes, 1..pr

## Operation
- Handshakes:
  - An input transfer occurs when `in_valid && in_ready` at a rising edge.
  - An output transfer occurs when `out_valid && out_ready` at a rising edge.
- Fill side has two states, FILL and FULL, plus a lane index `idx` (0..pr-1).
  - FILL: an accepted pair is written to lane `idx`.
    - If `idx==pr-1` or `in_last`: record length `idx+1`, set `idx←0`, go to FULL.
    - Otherwise `idx←idx+1`.
  - FULL: the buffer holds a complete vector. No lane writes unless the buffer is handed over in the same cycle (below).
- Output side has two states, EMPTY and VALID.
  - The output slot is free when EMPTY, or when VALID with `out_ready` high.
  - Hand-over: when the fill side is FULL and the output slot is free, the fill buffer and length copy into `out_a`/`out_b`/`out_len`. Output goes to VALID and fill side goes to FILL.
  - The fill buffer is cleared to all zeros on hand-over. Lanes not written before `in_last` therefore reach the output as 0.
  - VALID with `out_ready` high and no hand-over that cycle: go to EMPTY.
- `in_ready = (fill==FILL) || (output slot free)`.
- Simultaneous hand-over and input accept: the buffer becomes zeros except lane 0, which takes the new pair, and `idx←1`. If `in_last` is also set, or `pr` is reached, the fill side goes straight back to FULL with length 1.
- `in_a`/`in_b` are stored unmodified. Sign extension is the MAC's job.
- `in_valid` low: no state change on the fill side. Partial vectors are held indefinitely.
- `in_last` is ignored unless an input transfer occurs.
- Reset, asynchronous, any time including mid-vector:
  - fill buffer zero, `idx=0`, fill=FILL, output=EMPTY
  - `out_valid=0`, `out_a=0`, `out_b=0`, `out_len=0`
  - `in_ready=1` after reset deasserts
  - Any partial or pending vector is discarded.

## Timing
- Latency: the last lane is accepted at edge E. The fill side is FULL after E. With the output slot free, hand-over happens at E+1 and `out_valid` rises after E+1 (2 edges).
- Throughput: with `out_ready` held high, one vector every `pr` cycles. `in_ready` stays high continuously.
- Backpressure: `out_ready` low with output VALID and fill side FULL drops `in_ready` to 0 until the output transfer.
- `out_a`, `out_b`, `out_len` are registered and held stable while `out_valid && !out_ready`.
- `in_ready` is combinational from state and `out_ready`. No other combinational input-to-output paths.

## Structure
- Shared package holds:
  - defaults `BW=8`, `PR=8`
  - `LEN_W = $clog2(PR+1)`
  - the fill and output state encodings
- One sub-module, `vec_fill_buf`, instantiated twice (a and b).
  - Ports: `clk`, `reset`, `clr`, `we`, `idx`, `din`, `dout[pr*bw-1:0]`.
  - Behaviour: clear-with-write at lane 0 on simultaneous `clr` and `we`.
- Top level holds `idx`, both state machines and the output registers.

## Test plan
- Full vector: `pr=8`, stream a=1..8, b=-1 (0xFF), `out_ready=1`.
  - `out_a=0x0807060504030201`, `out_b=0xFFFFFFFFFFFFFFFF`, `out_len=8`.
  - `out_valid` rises 2 edges after lane 7 is accepted.
- Short vector: 3 pairs a=0x7F,0x80,0x01 with `in_last` on the third.
  - `out_a=0x0000000000018 07F` reading lanes 0..2 as 0x7F, 0x80, 0x01 and lanes 3..7 as 0x00, i.e. `out_a=0x000000000001807F`, `out_len=3`.
- Back-to-back streaming: 4 vectors, `in_valid` and `out_ready` constantly 1.
  - `in_ready` never drops.
  - 4 output transfers spaced 8 cycles apart, data intact.
- Backpressure: `out_ready=0` while 2 vectors are streamed.
  - After the second vector, `in_ready=0` and `out_a` is held.
  - Raising `out_ready` yields vector 1, then vector 2 one edge later.
- Edge case: hand-over in the same cycle as a length-1 vector with `in_last`.
  - Next output has lane 0 = new pair, all other lanes 0, `out_len=1`.
- Reset: assert `reset` asynchronously (between edges) after 5 lanes.
  - All outputs go to 0 immediately.
  - The next 8 pairs form a clean vector with no residue from the discarded lanes.
